cga_vram_arbiter: RTL

CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

---
 rtl/cga_pkg.sv | 14 +
 rtl/cga_bus_sync.sv | 23 ++
 rtl/cga_vram_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cga_pkg.sv
// Shared types and default sequencer constants for the CGA VRAM arbiter.
package cga_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    ACCESS    = 2'd2,
    HOLD      = 2'd3
  } cga_state_e;

  localparam logic [4:0] SEQ_LAST_DEF = 5'd31;
  localparam logic [4:0] CPU_SLOT_DEF = 5'd17;

endpackage

// File: rtl/cga_bus_sync.sv
// Two-flop synchroniser for active-low ISA strobes; resets to the inactive level.
module cga_bus_sync #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares VRAM between display fetch and one CPU access per sequencer slot.
// Define CGA_SNOW_EN to let the CPU byte leak onto disp_data after each access.
module cga_vram_arbiter
  import cga_pkg::*;
#(
  parameter int unsigned ADDR_W       = 15,
  parameter logic [4:0]  SEQ_LAST     = SEQ_LAST_DEF,
  parameter logic [4:0]  CPU_SLOT     = CPU_SLOT_DEF,
  parameter bit          USE_BUS_WAIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        clk_seq,
  input  logic              mem_cs,
  input  logic              bus_memr_l,
  input  logic              bus_memw_l,
  input  logic [ADDR_W-1:0] bus_a,
  input  logic [7:0]        bus_d,
  output logic [7:0]        bus_out,
  output logic              bus_rdy,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [7:0]        disp_data,
  output logic [ADDR_W-1:0] ram_a,
  input  logic [7:0]        ram_d,
  output logic [7:0]        ram_dout,
  output logic              ram_we_l
);

  if (CPU_SLOT > SEQ_LAST) begin : g_bad_slot
    $error("CPU_SLOT must not exceed SEQ_LAST");
  end
  if (ADDR_W < 14 || ADDR_W > 17) begin : g_bad_addr_w
    $error("ADDR_W must be in 14..17");
  end

  logic [1:0]        strb_s;
  logic              memr_s_l;
  logic              memw_s_l;
  cga_state_e        state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              wr_q;
  logic              entry_q;
  logic              bus_rdy_q;
  logic              in_access;
  logic              own_strb_l;
  logic              slot_hit;

  cga_bus_sync #(.W(2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({bus_memw_l, bus_memr_l}),
    .q     (strb_s)
  );

  assign memr_s_l   = strb_s[0];
  assign memw_s_l   = strb_s[1];
  assign in_access  = (state == ACCESS);
  assign own_strb_l = wr_q ? memw_s_l : memr_s_l;
  assign slot_hit   = (clk_seq == CPU_SLOT);

  // entry_q masks a slot match in the very first WAIT_SLOT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= 8'h00;
      wr_q      <= 1'b0;
      entry_q   <= 1'b0;
      bus_rdy_q <= 1'b1;
      bus_out   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (mem_cs && (memr_s_l != memw_s_l)) begin
            state     <= WAIT_SLOT;
            addr_q    <= bus_a;
            data_q    <= bus_d;
            wr_q      <= ~memw_s_l;
            entry_q   <= 1'b1;
            bus_rdy_q <= 1'b0;
          end
        end
        WAIT_SLOT: begin
          entry_q <= 1'b0;
          if (!wr_q && memr_s_l) begin
            state     <= IDLE;
            bus_rdy_q <= 1'b1;
          end else if (slot_hit && !entry_q) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          state     <= HOLD;
          bus_rdy_q <= 1'b1;
          if (!wr_q) bus_out <= ram_d;
        end
        HOLD: begin
          if (own_strb_l) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display pipeline; the slot following ACCESS carries the CPU byte or holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_data <= 8'h00;
    end else if (in_access) begin
`ifdef CGA_SNOW_EN
      disp_data <= wr_q ? data_q : ram_d;
`else
      disp_data <= disp_data;
`endif
    end else begin
      disp_data <= ram_d;
    end
  end

  // Reset gates the strobe so an ACCESS cycle under reset never writes.
  assign ram_a    = in_access ? addr_q : disp_addr;
  assign ram_dout = data_q;
  assign ram_we_l = ~(in_access && wr_q && !reset);
  assign bus_rdy  = USE_BUS_WAIT ? bus_rdy_q : 1'b1;

endmodule
